// File: rtl/dbg_pkg.sv
// Shared constants for the debug host bridge: command bytes, response codes,
// access-size encodings and the command FSM states.
package dbg_pkg;

    localparam logic [7:0] CMD_HALT    = 8'h48;
    localparam logic [7:0] CMD_GO      = 8'h47;
    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_WRITE_B = 8'h42;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] CMD_PC      = 8'h50;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_RD_CAP,
        ST_TX
    } state_e;

endpackage

// File: rtl/dbg_tx_shifter.sv
// Response serializer: holds up to four bytes and streams them LSB first
// over a valid/ready byte link.
module dbg_tx_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_cnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    logic [31:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load) begin
            sh_d  = load_data;
            cnt_d = load_cnt;
        end else if ((cnt_q != 3'd0) && tx_ready) begin
            sh_d  = {8'h00, sh_q[31:8]};
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign tx_data  = sh_q[7:0];
    assign tx_valid = (cnt_q != 3'd0);
    assign busy     = tx_valid;

endmodule

// File: rtl/dbg_host_bridge.sv
// Host byte-stream command engine driving the SoC debug memory port:
// halt/release the CPU, write/read memory and read the PC.
module dbg_host_bridge
    import dbg_pkg::*;
#(
    parameter bit          HALT_ON_RESET  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        debug,
    output logic [31:0] mem_addr_dbg,
    output logic [31:0] mem_wdata_dbg,
    output logic [1:0]  mem_byte_sel_dbg,
    output logic        mem_we_dbg,
    input  logic [31:0] mem_rdata_dbg,
    input  logic [31:0] pc
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      addr_sh_q, addr_sh_d;
    logic [31:0]      data_sh_q, data_sh_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       sel_q, sel_d;
    logic             debug_q, debug_d;
    logic             pc_pend_q, pc_pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic        rx_fire, last, ld, tx_busy;
    logic [31:0] ld_data;
    logic [2:0]  ld_cnt;

    assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign rx_fire  = rx_valid && rx_ready;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        debug_d   = debug_q;
        pc_pend_d = pc_pend_q;
        tmo_d     = '0;
        last      = 1'b0;
        ld        = 1'b0;
        ld_data   = '0;
        ld_cnt    = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    cmd_d = rx_data;
                    cnt_d = '0;
                    case (rx_data)
                        CMD_HALT, CMD_GO: begin
                            debug_d = (rx_data == CMD_HALT);
                            ld      = 1'b1;
                            ld_data = {24'h0, ACK};
                            ld_cnt  = 3'd1;
                            state_d = ST_TX;
                        end
                        CMD_WRITE, CMD_WRITE_B, CMD_READ: state_d = ST_ADDR;
                        CMD_PC: begin
                            pc_pend_d = 1'b1;
                            state_d   = ST_TX;
                        end
                        default: begin
                            ld      = 1'b1;
                            ld_data = {24'h0, NAK};
                            ld_cnt  = 3'd1;
                            state_d = ST_TX;
                        end
                    endcase
                end
            end
            ST_ADDR, ST_DATA: begin
                if (rx_fire) begin
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ST_ADDR) begin
                        addr_sh_d = {rx_data, addr_sh_q[31:8]};
                        if (cnt_q == 2'd3) begin
                            if (cmd_q == CMD_READ) last = 1'b1;
                            else state_d = ST_DATA;
                        end
                    end else begin
                        data_sh_d = {rx_data, data_sh_q[31:8]};
                        last      = (cmd_q == CMD_WRITE_B) || (cnt_q == 2'd3);
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_MEM_WR: begin
                ld      = 1'b1;
                ld_data = {24'h0, ACK};
                ld_cnt  = 3'd1;
                state_d = ST_TX;
            end
            ST_MEM_RD: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                ld      = 1'b1;
                ld_data = mem_rdata_dbg;
                ld_cnt  = 3'd4;
                state_d = ST_TX;
            end
            ST_TX: begin
                // PC is captured one cycle after the 'P' byte was accepted.
                if (pc_pend_q) begin
                    ld        = 1'b1;
                    ld_data   = pc;
                    ld_cnt    = 3'd4;
                    pc_pend_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands complete: a running CPU owns memory, so refuse the access.
        if (last) begin
            if (!debug_q) begin
                ld      = 1'b1;
                ld_data = {24'h0, NAK};
                ld_cnt  = 3'd1;
                state_d = ST_TX;
            end else begin
                addr_d = addr_sh_d;
                case (cmd_q)
                    CMD_WRITE: begin
                        wdata_d = data_sh_d;
                        sel_d   = SZ_WORD;
                        state_d = ST_MEM_WR;
                    end
                    CMD_WRITE_B: begin
                        wdata_d = {24'h0, rx_data};
                        sel_d   = SZ_BYTE;
                        state_d = ST_MEM_WR;
                    end
                    default: begin
                        sel_d   = SZ_WORD;
                        state_d = ST_MEM_RD;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= SZ_WORD;
            debug_q   <= HALT_ON_RESET;
            pc_pend_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            debug_q   <= debug_d;
            pc_pend_q <= pc_pend_d;
            tmo_q     <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_sh_q <= addr_sh_d;
        data_sh_q <= data_sh_d;
    end

    dbg_tx_shifter u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .load_data (ld_data),
        .load_cnt  (ld_cnt),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (tx_busy)
    );

    assign debug            = debug_q;
    assign mem_addr_dbg     = addr_q;
    assign mem_wdata_dbg    = wdata_q;
    assign mem_byte_sel_dbg = sel_q;
    assign mem_we_dbg       = (state_q == ST_MEM_WR);

endmodule
